// File: rtl/result_frame_buffer_pkg.sv
// Shared image-pipeline definitions: frame geometry defaults, skid depth and
// the scan FSM encoding used by the result frame buffer and its neighbours.
package result_frame_buffer_pkg;

  localparam int DEF_WIDTH_BITS  = 8;
  localparam int DEF_HEIGHT_BITS = 8;
  localparam int DEF_COLOR_BITS  = 3;
  localparam int SKID_DEPTH      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  function automatic int pixel_bits(input int color_bits);
    return 3 * color_bits;
  endfunction

endpackage

// File: rtl/result_frame_buffer_if.sv
// Pixel write port plus valid/ready scan readout bundle of the result frame buffer.
// The master side writes pixels and consumes the scan; the slave side is the buffer.
interface result_frame_buffer_if
  import result_frame_buffer_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int COLOR_BITS  = DEF_COLOR_BITS
);

  logic [WIDTH_BITS-1:0]  iX;
  logic [HEIGHT_BITS-1:0] iY;
  logic [COLOR_BITS-1:0]  iR;
  logic [COLOR_BITS-1:0]  iG;
  logic [COLOR_BITS-1:0]  iB;
  logic                   iWren;
  logic                   iScanStart;
  logic [WIDTH_BITS-1:0]  oX;
  logic [HEIGHT_BITS-1:0] oY;
  logic [COLOR_BITS-1:0]  oR;
  logic [COLOR_BITS-1:0]  oG;
  logic [COLOR_BITS-1:0]  oB;
  logic                   oValid;
  logic                   iReady;
  logic                   oBusy;
  logic                   oFrameDone;

  modport master (
    output iX, iY, iR, iG, iB, iWren, iScanStart, iReady,
    input  oX, oY, oR, oG, oB, oValid, oBusy, oFrameDone
  );

  modport slave (
    input  iX, iY, iR, iG, iB, iWren, iScanStart, iReady,
    output oX, oY, oR, oG, oB, oValid, oBusy, oFrameDone
  );

endinterface

// File: rtl/result_frame_buffer_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered read. A same-address write and read return the old word.
module result_ram #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 9
) (
  input  logic                 clock,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o
);

  logic [DATA_BITS-1:0] mem_q [0:(1<<ADDR_BITS)-1];
  logic [DATA_BITS-1:0] rd_data_q;

  // Contents are deliberately not reset so the frame survives a scan abort.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/result_frame_buffer.sv
// Result frame buffer: random pixel writes into a frame store and a raster
// readout over valid/ready, fed by a read prefetch into a 2-entry skid buffer.
module result_frame_buffer
  import result_frame_buffer_pkg::*;
#(
  parameter int WIDTH_BITS  = DEF_WIDTH_BITS,
  parameter int HEIGHT_BITS = DEF_HEIGHT_BITS,
  parameter int COLOR_BITS  = DEF_COLOR_BITS
) (
  input logic                  clock,
  input logic                  not_reset,
  result_frame_buffer_if.slave bus
);

  localparam int PIX_BITS  = pixel_bits(COLOR_BITS);
  localparam int ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;

  scan_state_e            state_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   valid_q, valid_d;
  logic [WIDTH_BITS-1:0]  rd_x_q, rd_x_d;
  logic [HEIGHT_BITS-1:0] rd_y_q, rd_y_d;
  logic                   rd_done_q, rd_done_d;
  logic                   infl_q;
  logic [WIDTH_BITS-1:0]  infl_x_q;
  logic [HEIGHT_BITS-1:0] infl_y_q;
  logic [1:0]             cnt_q, cnt_d;
  logic [1:0]             occ;
  logic [WIDTH_BITS-1:0]  ent_x_q [SKID_DEPTH];
  logic [WIDTH_BITS-1:0]  ent_x_d [SKID_DEPTH];
  logic [HEIGHT_BITS-1:0] ent_y_q [SKID_DEPTH];
  logic [HEIGHT_BITS-1:0] ent_y_d [SKID_DEPTH];
  logic [PIX_BITS-1:0]    ent_p_q [SKID_DEPTH];
  logic [PIX_BITS-1:0]    ent_p_d [SKID_DEPTH];
  logic                   pop, push, rd_issue, last_pop, wsel;
  logic [PIX_BITS-1:0]    rd_data;

  result_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (PIX_BITS)
  ) u_ram (
    .clock     (clock),
    .wr_en_i   (bus.iWren),
    .wr_addr_i ({bus.iY, bus.iX}),
    .wr_data_i ({bus.iR, bus.iG, bus.iB}),
    .rd_en_i   (rd_issue),
    .rd_addr_i ({rd_y_q, rd_x_q}),
    .rd_data_o (rd_data)
  );

  // A read is issued only if its result is guaranteed a skid slot when it lands.
  always_comb begin
    pop      = valid_q && bus.iReady;
    push     = infl_q;
    occ      = cnt_q + {1'b0, infl_q};
    rd_issue = (state_q == ST_SCAN) && !rd_done_q &&
               ((occ < 2'd2) || (pop && (occ == 2'd2)));
    last_pop = pop && (state_q == ST_SCAN) && (&ent_x_q[0]) && (&ent_y_q[0]);
  end

  always_comb begin
    rd_x_d    = rd_x_q;
    rd_y_d    = rd_y_q;
    rd_done_d = rd_done_q;
    if (state_q == ST_IDLE) begin
      rd_x_d    = '0;
      rd_y_d    = '0;
      rd_done_d = 1'b0;
    end else if (rd_issue) begin
      if ((&rd_x_q) && (&rd_y_q)) begin
        rd_done_d = 1'b1;
      end else if (&rd_x_q) begin
        rd_x_d = '0;
        rd_y_d = rd_y_q + 1'b1;
      end else begin
        rd_x_d = rd_x_q + 1'b1;
      end
    end
  end

  // Entry 0 is the presented beat; a pop shifts entry 1 forward.
  always_comb begin
    ent_x_d = ent_x_q;
    ent_y_d = ent_y_q;
    ent_p_d = ent_p_q;
    if (pop) begin
      ent_x_d[0] = ent_x_q[1];
      ent_y_d[0] = ent_y_q[1];
      ent_p_d[0] = ent_p_q[1];
    end
    wsel = pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
    if (push) begin
      ent_x_d[wsel] = infl_x_q;
      ent_y_d[wsel] = infl_y_q;
      ent_p_d[wsel] = rd_data;
    end
    cnt_d   = cnt_q + {1'b0, push} - {1'b0, pop};
    valid_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (bus.iScanStart) begin
          state_q <= ST_SCAN;
          busy_q  <= 1'b1;
        end
        ST_SCAN: if (last_pop) begin
          state_q      <= ST_DONE;
          frame_done_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!not_reset) begin
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      rd_done_q <= 1'b0;
      infl_q    <= 1'b0;
      infl_x_q  <= '0;
      infl_y_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        ent_x_q[i] <= '0;
        ent_y_q[i] <= '0;
        ent_p_q[i] <= '0;
      end
    end else begin
      rd_x_q    <= rd_x_d;
      rd_y_q    <= rd_y_d;
      rd_done_q <= rd_done_d;
      infl_q    <= rd_issue;
      infl_x_q  <= rd_x_q;
      infl_y_q  <= rd_y_q;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      for (int i = 0; i < SKID_DEPTH; i++) begin
        ent_x_q[i] <= ent_x_d[i];
        ent_y_q[i] <= ent_y_d[i];
        ent_p_q[i] <= ent_p_d[i];
      end
    end
  end

  assign bus.oX         = ent_x_q[0];
  assign bus.oY         = ent_y_q[0];
  assign bus.oR         = ent_p_q[0][PIX_BITS-1 -: COLOR_BITS];
  assign bus.oG         = ent_p_q[0][2*COLOR_BITS-1 -: COLOR_BITS];
  assign bus.oB         = ent_p_q[0][COLOR_BITS-1:0];
  assign bus.oValid     = valid_q;
  assign bus.oBusy      = busy_q;
  assign bus.oFrameDone = frame_done_q;

endmodule

// File: tb/tb_result_frame_buffer.sv
// Scoreboard bench for result_frame_buffer on a reduced 128x8 frame: scans push
// expected beats, a negedge monitor pops and compares every accepted beat.
module tb_result_frame_buffer;
  import result_frame_buffer_pkg::*;

  localparam int WB = 7;
  localparam int HB = 3;
  localparam int CB = 3;
  localparam int W  = 1 << WB;
  localparam int H  = 1 << HB;
  localparam int N  = W * H;
  localparam int PB = 3 * CB;

  typedef struct packed {
    logic [WB-1:0] x;
    logic [HB-1:0] y;
    logic [PB-1:0] p;
  } beat_t;

  logic clock     = 1'b0;
  logic not_reset = 1'b0;

  result_frame_buffer_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .COLOR_BITS(CB)) bus ();

  result_frame_buffer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .COLOR_BITS(CB)) dut (
    .clock     (clock),
    .not_reset (not_reset),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int          errors   = 0;
  int          checks   = 0;
  int          done_cnt = 0;
  int          accepted = 0;
  bit          done_due = 1'b0;
  beat_t       exp_q[$];
  logic [PB-1:0] model_mem [N];
  int          ready_mode   = 0;
  logic        manual_ready = 1'b1;
  logic        rnd_ready    = 1'b1;

  // iReady source: 0 = always ready, 1 = random, 2 = manual.
  always_comb begin
    bus.iReady = 1'b1;
    if (ready_mode == 1)      bus.iReady = rnd_ready;
    else if (ready_mode == 2) bus.iReady = manual_ready;
  end

  always @(posedge clock) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: compares each accepted beat and the end-of-frame pulse.
  always @(negedge clock) begin
    beat_t got, want;
    if (not_reset) begin
      if (bus.oFrameDone || done_due) begin
        chk("frame_done_pulse", 32'(bus.oFrameDone), 32'(done_due));
        if (done_due) chk("valid_after_last", 32'(bus.oValid), 32'd0);
      end
      if (bus.oFrameDone) done_cnt++;
      done_due = 1'b0;
      if (bus.oValid && bus.iReady) begin
        got.x = bus.oX;
        got.y = bus.oY;
        got.p = {bus.oR, bus.oG, bus.oB};
        accepted++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got unexpected (%0d,%0d) rgb=%03o required no beat",
                   got.x, got.y, got.p);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL beat: got (%0d,%0d) rgb=%03o required (%0d,%0d) rgb=%03o",
                     got.x, got.y, got.p, want.x, want.y, want.p);
          end
          if ((&want.x) && (&want.y)) done_due = 1'b1;
        end
      end
    end else begin
      done_due = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_write(input int x, input int y, input logic [PB-1:0] p);
    bus.iWren = 1'b1;
    bus.iX    = WB'(x);
    bus.iY    = HB'(y);
    {bus.iR, bus.iG, bus.iB} = p;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        b.x = WB'(x);
        b.y = HB'(y);
        b.p = model_mem[y*W + x];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic start_scan();
    push_frame();
    bus.iScanStart = 1'b1;
    tick();
    bus.iScanStart = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (bus.oBusy && n < max) begin
      tick();
      n++;
    end
    checks++;
    if (bus.oBusy) begin
      errors++;
      $display("FAIL %s: got busy after %0d cycles required idle", name, max);
    end
  endtask

  task automatic check_scan_end(input string name, input int d0, input int a0, input int beats);
    chk({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    chk({name, "_beats"}, 32'(accepted - a0), 32'(beats));
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got time limit reached required scan completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0, a0, n;
    bit found;
    bus.iX = '0; bus.iY = '0; bus.iR = '0; bus.iG = '0; bus.iB = '0;
    bus.iWren = 1'b0; bus.iScanStart = 1'b0;

    // Reset state
    not_reset = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.oValid), 32'd0);
    chk("rst_busy", 32'(bus.oBusy), 32'd0);
    chk("rst_done", 32'(bus.oFrameDone), 32'd0);
    chk("rst_x", 32'(bus.oX), 32'd0);
    chk("rst_y", 32'(bus.oY), 32'd0);
    chk("rst_rgb", 32'({bus.oR, bus.oG, bus.oB}), 32'd0);
    not_reset = 1'b1;
    tick();

    // Full-frame write: R=X[2:0], G=Y[2:0], B=3'b101
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        drive_write(x, y, {CB'(x), CB'(y), 3'b101});
        model_mem[y*W + x] = {CB'(x), CB'(y), 3'b101};
        tick();
      end
    end
    bus.iWren = 1'b0;

    // Full scan with iReady=1 and start latency checks
    d0 = done_cnt; a0 = accepted;
    push_frame();
    bus.iScanStart = 1'b1;
    tick();
    bus.iScanStart = 1'b0;
    chk("lat_busy_e0", 32'(bus.oBusy), 32'd1);
    chk("lat_valid_e0", 32'(bus.oValid), 32'd0);
    tick();
    chk("lat_valid_e1", 32'(bus.oValid), 32'd0);
    tick();
    chk("lat_valid_e2", 32'(bus.oValid), 32'd1);
    chk("lat_first_xy", 32'({bus.oY, bus.oX}), 32'd0);
    wait_idle("full_scan", N + 20);
    check_scan_end("full_scan", d0, a0, N);

    // Backpressure at beat (3,0)
    d0 = done_cnt; a0 = accepted;
    manual_ready = 1'b1;
    ready_mode = 2;
    start_scan();
    found = 1'b0;
    n = 0;
    while (!found && n < 50) begin
      if (bus.oValid && bus.oX == WB'(3) && bus.oY == HB'(0)) found = 1'b1;
      else begin tick(); n++; end
    end
    chk("bp_found", 32'(found), 32'd1);
    manual_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.oValid), 32'd1);
      chk("bp_hold_x", 32'(bus.oX), 32'd3);
      chk("bp_hold_y", 32'(bus.oY), 32'd0);
      chk("bp_hold_rgb", 32'({bus.oR, bus.oG, bus.oB}), 32'(model_mem[3]));
    end
    manual_ready = 1'b1;
    tick();
    chk("bp_resume_valid", 32'(bus.oValid), 32'd1);
    chk("bp_resume_x", 32'(bus.oX), 32'd4);
    chk("bp_resume_y", 32'(bus.oY), 32'd0);
    ready_mode = 0;
    wait_idle("backpressure", N + 40);
    check_scan_end("backpressure", d0, a0, N);

    // Random iReady over a full frame
    d0 = done_cnt; a0 = accepted;
    ready_mode = 1;
    start_scan();
    wait_idle("random_ready", 8 * N);
    ready_mode = 0;
    check_scan_end("random_ready", d0, a0, N);

    // Same-cycle write/read collision at (10,0)
    drive_write(10, 0, '0);
    model_mem[10] = '0;
    tick();
    bus.iWren = 1'b0;
    d0 = done_cnt; a0 = accepted;
    start_scan();
    repeat (10) tick();
    drive_write(10, 0, '1);
    tick();
    bus.iWren = 1'b0;
    model_mem[10] = '1;
    wait_idle("collision", N + 20);
    check_scan_end("collision", d0, a0, N);
    d0 = done_cnt; a0 = accepted;
    start_scan();
    wait_idle("collision_rescan", N + 20);
    check_scan_end("collision_rescan", d0, a0, N);

    // Reset mid-scan at beat (100,5); a write during reset must still land
    d0 = done_cnt;
    manual_ready = 1'b1;
    ready_mode = 2;
    start_scan();
    found = 1'b0;
    n = 0;
    while (!found && n < 2 * N) begin
      if (bus.oValid && bus.oX == WB'(100) && bus.oY == HB'(5)) found = 1'b1;
      else begin tick(); n++; end
    end
    chk("mid_rst_found", 32'(found), 32'd1);
    not_reset = 1'b0;
    manual_ready = 1'b0;
    drive_write(1, 0, 9'o123);
    exp_q.delete();
    tick();
    bus.iWren = 1'b0;
    model_mem[1] = 9'o123;
    chk("mid_rst_valid", 32'(bus.oValid), 32'd0);
    chk("mid_rst_busy", 32'(bus.oBusy), 32'd0);
    chk("mid_rst_done", 32'(bus.oFrameDone), 32'd0);
    not_reset = 1'b1;
    ready_mode = 0;
    repeat (3) tick();
    chk("mid_rst_no_pulse", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt; a0 = accepted;
    start_scan();
    wait_idle("after_reset", N + 20);
    check_scan_end("after_reset", d0, a0, N);

    // Repeated iScanStart during a scan
    d0 = done_cnt; a0 = accepted;
    start_scan();
    for (int i = 0; i < N - 20; i++) begin
      bus.iScanStart = (i % 3 == 0);
      tick();
    end
    bus.iScanStart = 1'b0;
    wait_idle("restart_ignored", 100);
    repeat (5) tick();
    check_scan_end("restart_ignored", d0, a0, N);
    chk("restart_idle_busy", 32'(bus.oBusy), 32'd0);
    chk("restart_idle_valid", 32'(bus.oValid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/result_frame_buffer.md
RESULT_FRAME_BUFFER -- requirements
Module: result_frame_buffer

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 8, column address width (WIDTH = 2**WIDTH_BITS).
REQ-002 SHALL have parameter HEIGHT_BITS, default 8, row address width (HEIGHT = 2**HEIGHT_BITS).
REQ-003 SHALL have parameter COLOR_BITS, default 3, per-channel colour width.
REQ-004 SHALL use one clock and a synchronous, active-low reset:
- clock  in  1  sole clock, rising edge.
- not_reset  in  1  synchronous active-low reset.
REQ-005 SHALL have the write-side ports:
- iX  in  WIDTH_BITS  pixel column.
- iY  in  HEIGHT_BITS  pixel row.
- iR/iG/iB  in  COLOR_BITS each  pixel colour.
- iWren  in  1  write strobe, one pixel per cycle.
REQ-006 SHALL have the scan-side ports:
- iScanStart  in  1  request a full-frame readout.
- oX  out  WIDTH_BITS  readout column.
- oY  out  HEIGHT_BITS  readout row.
- oR/oG/oB  out  COLOR_BITS each  readout colour.
- oValid  out  1  readout beat valid.
- iReady  in  1  downstream accepts the beat.
- oBusy  out  1  scan in progress.
- oFrameDone  out  1  one-cycle end-of-scan pulse.

Function
REQ-007 SHALL store the concatenation {iR,iG,iB} at address {iY,iX} on every rising edge with iWren=1, in every state, including during a scan.
REQ-008 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-009 SHALL go IDLE->SCAN when iScanStart=1 is sampled in IDLE, and SHALL ignore iScanStart in SCAN and DONE.
REQ-010 SHALL raster-order the scan: X is inner, 0..WIDTH-1; Y is outer, 0..HEIGHT-1; exactly WIDTH*HEIGHT beats per scan.
REQ-011 SHALL assert oValid after the second rising edge following the edge that sampled iScanStart.
REQ-012 SHALL accept a beat when oValid=1 and iReady=1 on a rising edge.
REQ-013 SHALL hold oX, oY, oR, oG, oB and oValid stable while oValid=1 and iReady=0.
REQ-014 SHALL sustain one beat per cycle while iReady=1, using a read prefetch plus a 2-entry skid buffer with no bubbles.
REQ-015 SHALL report with each beat the stored data for the oX/oY it carries.
REQ-016 SHALL return the old memory data when a write and a scan read hit the same address in the same cycle (read-before-write).
REQ-017 SHALL, on acceptance of beat (WIDTH-1, HEIGHT-1), go to DONE and deassert oValid the next cycle; the read counter SHALL NOT wrap or issue further reads.
REQ-018 SHALL pulse oFrameDone=1 for exactly the one cycle spent in DONE, then go to IDLE.
REQ-019 SHALL drive oBusy=1 in SCAN and DONE, 0 in IDLE.
REQ-020 SHALL keep oValid=0 in IDLE.
REQ-021 SHALL treat iReady toggling every cycle as legal, with no beat lost or duplicated.

Reset
REQ-022 SHALL, on the edge sampling not_reset=0, set the state to IDLE, clear the counters and skid buffer, and drive oValid=0, oBusy=0, oFrameDone=0, oX=0, oY=0, oR=0, oG=0, oB=0.
REQ-023 SHALL abort any scan in progress on reset with no oFrameDone pulse.
REQ-024 SHALL NOT clear memory contents on reset, and SHALL NOT block writes by reset.

Structure
REQ-025 SHALL keep WIDTH_BITS, HEIGHT_BITS, COLOR_BITS defaults and the FSM state encoding in the shared image package used by the other pipeline stages.
REQ-026 SHALL instantiate one sub-module, result_ram: simple dual-port, 1 write port, 1 read port, 1-cycle registered read latency, depth WIDTH*HEIGHT, width 3*COLOR_BITS.

Verification
REQ-027 SHALL cover full-frame write then scan: write R=X[2:0], G=Y[2:0], B=3'b101 at all 65536 addresses; pulse iScanStart; iReady=1 -> 65536 beats with matching data, oValid first high 2 cycles after the start edge, oFrameDone pulse 1 cycle after the (255,255) beat.
REQ-028 SHALL cover backpressure: iReady=0 for 10 cycles at beat (3,0) -> outputs frozen at (3,0); resume -> (4,0) next, no loss or duplicate.
REQ-029 SHALL cover random iReady (50%) over a full frame -> exactly 65536 accepted beats, in order, data correct.
REQ-030 SHALL cover a same-cycle collision: write (10,0)=3'b111 in the cycle its read issues during a scan, old value 0 -> beat (10,0) returns 0; a rescan returns 3'b111.
REQ-031 SHALL cover reset mid-scan: not_reset=0 at beat (100,5) -> next cycle oValid=0, oBusy=0, no oFrameDone; a new scan restarts at (0,0) with data intact.
REQ-032 SHALL cover iScanStart asserted repeatedly during a scan -> exactly one scan and one oFrameDone.
